// File: rtl/comm_pkg.sv
// Shared types and default constants for the comm_slave command receiver.
package comm_pkg;

  // Default bit period: 25 MHz / 9600 baud.
  localparam int unsigned BAUD_DIV_DEF    = 2604;
  // Default allowance between high and low byte: about 20 bit times.
  localparam int unsigned TIMEOUT_CYC_DEF = 52080;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic {
    ASM_IDLE,
    ASM_HIGH_RCVD
  } asm_state_e;

endpackage

// File: rtl/comm_slave_if.sv
// Serial command link: UART line in, assembled 16-bit command out.
interface comm_slave_if;
  logic        RX;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;

  modport slave (
    input  RX,
    input  clr_cmd_rdy,
    output cmd,
    output cmd_rdy
  );

  modport master (
    output RX,
    output clr_cmd_rdy,
    input  cmd,
    input  cmd_rdy
  );
endinterface

// File: rtl/comm_slave_uart_rx.sv
// 8N1 UART receiver: RX synchroniser, baud down-counter, bit counter, LSB-first
// shifter and a one-cycle byte strobe on a good stop bit.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   RX_IDLE  | waiting for a synchronised falling edge on the line
//   RX_START | counting half a bit, then re-checking the start bit
//   RX_DATA  | sampling 8 data bits, one per bit period
//   RX_STOP  | sampling the stop bit; strobe the byte if it reads 1
module uart_rx
  import comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o
);

  localparam int unsigned CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_rx: BAUD_DIV must be at least 2");
  end

  logic       rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       tc;
  logic       fall;

  // Two-flop synchroniser plus one history flop for edge detection; idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign tc   = (cnt_q == '0);
  assign fall = rx_prev_q & ~rx_sync_q;

  // Receiver state, baud counter, bit counter and shifter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  // Next-state logic; every sample happens when the down-counter hits zero.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    byte_vld_o = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d = RX_START;
          cnt_d   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (!tc) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_sync_q) begin
          state_d = RX_IDLE;       // glitch, not a real start bit
        end else begin
          state_d = RX_DATA;
          cnt_d   = FULL_LOAD;
          bit_d   = '0;
        end
      end
      RX_DATA: begin
        if (!tc) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          sh_d  = {rx_sync_q, sh_q[7:1]};
          cnt_d = FULL_LOAD;
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (!tc) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d    = RX_IDLE;
          byte_vld_o = rx_sync_q;  // framing error drops the byte silently
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o = sh_q;

endmodule

// File: rtl/comm_slave.sv
// Two-byte command assembler on top of uart_rx. High byte arrives first; the
// completed command is flagged by cmd_rdy until consumed or overwritten.
// Optional build macro CMD_TIMEOUT_EN: abandon a lone high byte after
// TIMEOUT_CYC cycles without a low byte.
//
//   state         | meaning
//   --------------+--------------------------------------------------------
//   ASM_IDLE      | expecting the high byte of a new command
//   ASM_HIGH_RCVD | high byte loaded into cmd[15:8], expecting the low byte
module comm_slave
  import comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV    = BAUD_DIV_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  comm_slave_if.slave  bus
);

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("comm_slave: TIMEOUT_CYC must be at least 1");
  end

  logic [7:0]  rx_byte;
  logic        rx_vld;
  asm_state_e  state_q, state_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        timeout;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (bus.RX),
    .byte_o     (rx_byte),
    .byte_vld_o (rx_vld)
  );

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Timeout down-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end

  // Reload when the high byte lands, then count down while waiting.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == ASM_IDLE) begin
      if (rx_vld) tmo_d = TMO_LOAD;
    end else if (tmo_q != '0) begin
      tmo_d = tmo_q - 1'b1;
    end
  end

  assign timeout = (state_q == ASM_HIGH_RCVD) && (tmo_q == '0);
`else
  assign timeout = 1'b0;
`endif

  // Assembly state and command output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ASM_IDLE;
      cmd_q     <= 16'h0000;
      cmd_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  // Byte sequencing; a completing low byte outranks a same-cycle clear.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (bus.clr_cmd_rdy) cmd_rdy_d = 1'b0;
    case (state_q)
      ASM_IDLE: begin
        if (rx_vld) begin
          cmd_d[15:8] = rx_byte;
          cmd_rdy_d   = 1'b0;
          state_d     = ASM_HIGH_RCVD;
        end
      end
      ASM_HIGH_RCVD: begin
        if (rx_vld) begin
          cmd_d[7:0] = rx_byte;
          cmd_rdy_d  = 1'b1;
          state_d    = ASM_IDLE;
        end else if (timeout) begin
          state_d = ASM_IDLE;        // cmd and cmd_rdy left as they are
        end
      end
      default: state_d = ASM_IDLE;
    endcase
  end

  assign bus.cmd     = cmd_q;
  assign bus.cmd_rdy = cmd_rdy_q;

endmodule
